seq_det_param_moore: RTL and testbench
======================================

SEQ_DET_PARAM_MOORE -- requirements
Module: seq_det_param_moore

Interface
REQ-001 Parameter: PAT_W, default 3, pattern length in bits; legal range 2..16.
REQ-002 Parameter: CNT_W, default 8, width of the detection counter.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: x  input  1  serial data bit, sampled on the rising clk edge when en=1.
REQ-006 Port: en  input  1  bit-valid qualifier; x is ignored when en=0.
REQ-007 Port: pat  input  PAT_W  target pattern; pat[PAT_W-1] is the first bit received.
REQ-008 Port: pat_load  input  1  single-cycle pulse that latches pat and restarts detection.
REQ-009 Port: overlap  input  1  1=overlapping detection, 0=non-overlapping; sampled on every accepted bit.
REQ-010 Port: y  output  1  Moore detect flag, registered.
REQ-011 Port: armed  output  1  high while a pattern is loaded (state SCAN or HIT).
REQ-012 Port: det_cnt  output  CNT_W  number of detections since the last load or reset.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (no pattern loaded), SCAN, and HIT; y=1 only in HIT.
REQ-014 Internal state: pattern register pat_r (PAT_W), history shift register hist (PAT_W), and fill counter fill (0..PAT_W) giving the number of valid bits in hist.
REQ-015 Accepted bit (en=1, pat_load=0, state SCAN/HIT): hist <= {hist[PAT_W-2:0], x}; fill increments, saturating at PAT_W.
REQ-016 A match SHALL occur when the updated fill equals PAT_W and the updated hist equals pat_r; next state is HIT, else SCAN.
REQ-017 Latency: y SHALL be 1 in the cycle immediately after the edge that sampled the final pattern bit, for exactly one cycle per match.
REQ-018 HIT with an accepted, matching bit SHALL remain in HIT (back-to-back detections); otherwise HIT SHALL return to SCAN after one cycle.
REQ-019 On a match with overlap=1, hist and fill SHALL be kept; with overlap=0, hist and fill SHALL be cleared to 0.
REQ-020 en=0 in SCAN/HIT: hist and fill hold; HIT returns to SCAN; no match is evaluated.
REQ-021 In IDLE, x and en SHALL be ignored; y=0 and armed=0.
REQ-022 pat_load=1 from any state: pat_r <= pat; hist and fill <= 0; det_cnt <= 0; next state SCAN; y=0 next cycle.
REQ-023 pat_load takes priority over a same-cycle accepted bit; that bit SHALL be discarded.
REQ-024 det_cnt SHALL increment by 1 on every match and saturate at 2^CNT_W-1 without wrap-around.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE, pat_r=0, hist=0, fill=0, y=0, armed=0, det_cnt=0.
REQ-026 Reset asserted mid-pattern SHALL discard all partial history; after release, a pat_load is required before any detection.
REQ-027 Reset deassertion is taken synchronously with clk by the surrounding design; no extra recovery cycles are required.

Configuration
REQ-028 Macro SEQ_DET_COUNT_EN: when defined, det_cnt is implemented as specified in REQ-012, REQ-022 and REQ-024.
REQ-029 When SEQ_DET_COUNT_EN is undefined, the det_cnt port SHALL remain present and be tied to 0, and no counter logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-030 Reset, then 5 cycles with en=1 and random x and no pat_load -> y=0, armed=0, det_cnt=0 throughout.
REQ-031 PAT_W=3, load pat=101, overlap=1, stream 0,1,1,1,0,1,0,0,1,0,1,0,1 -> y pulses after bits 6, 11 and 13; det_cnt=3.
REQ-032 Same stream with overlap=0 -> y pulses after bits 6 and 11 only; det_cnt=2.
REQ-033 pat=101, stream 1,0 then en=0 for 3 cycles then x=1 with en=1 -> single y pulse after that bit; hist held across the gap.
REQ-034 pat=11, overlap=1, 5 consecutive 1s -> y high for 4 consecutive cycles; pat_load on the same cycle as bit 3 -> bit 3 discarded, det_cnt cleared to 0.
REQ-035 Assert rst mid-pattern (after 1,0 of 101) -> y=0 immediately, state IDLE; CNT_W=2 with 5 matches -> det_cnt saturates at 3; with macro undefined -> det_cnt=0 always.

Source files
------------

// File: rtl/seq_det_param_moore.sv
// seq_det_param_moore: loadable-pattern serial sequence detector, Moore output, optional overlap.
// Define SEQ_DET_COUNT_EN to build the saturating detection counter; otherwise det_cnt is tied to 0.
module seq_det_param_moore #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] det_cnt
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, hist_n;
  logic [FW-1:0] fill_q, fill_d, fill_n;
  logic acc, match;
  always_comb begin
    acc = en && !pat_load && state_q != IDLE;
    hist_n = {hist_q[PAT_W-2:0], x};
    fill_n = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    match = acc && fill_n == FULL && hist_n == pat_q;
    pat_d = pat_load ? pat : pat_q;
    state_d = pat_load ? SCAN : (state_q == IDLE) ? IDLE : match ? HIT : SCAN;
    // a non-overlapping match starts the next search from an empty history
    hist_d = (pat_load || (match && !overlap)) ? '0 : acc ? hist_n : hist_q;
    fill_d = (pat_load || (match && !overlap)) ? '0 : acc ? fill_n : fill_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
  assign y = state_q == HIT;
  assign armed = state_q != IDLE;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = pat_load ? '0 : (match && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign det_cnt = cnt_q;
`else
  assign det_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_det_param_moore.sv
// tb_seq_det_param_moore: directed checks of the sequence detector at PAT_W=3, CNT_W=8.
module tb_seq_det_param_moore;
  localparam int PAT_W = 3;
  localparam int CNT_W = 8;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic en = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic pat_load = 1'b0;
  logic overlap = 1'b0;
  logic y, armed;
  logic [CNT_W-1:0] det_cnt;
  int n_vec = 0;
  int n_err = 0;

  seq_det_param_moore #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat(pat), .pat_load(pat_load),
    .overlap(overlap), .y(y), .armed(armed), .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    return CNT_ON ? CNT_W'(n) : '0;
  endfunction

  task automatic tick(input logic xv, input logic ev, input logic lv);
    x = xv;
    en = ev;
    pat_load = lv;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic ov);
    pat = p;
    overlap = ov;
    tick(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (armed !== 1'b1 || y !== 1'b0 || det_cnt !== '0) begin
      n_err++;
      $display("FAIL load: armed=%b y=%b cnt=%0d, required armed=1 y=0 cnt=0", armed, y, det_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (y !== 1'b0 || armed !== 1'b0 || det_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_state: y=%b armed=%b cnt=%0d, required 0 0 0", y, armed, det_cnt);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_vec++;
      if (y !== 1'b0 || armed !== 1'b0 || det_cnt !== '0) begin
        n_err++;
        $display("FAIL idle_ignore[%0d]: y=%b armed=%b cnt=%0d, required 0 0 0", i, y, armed, det_cnt);
      end
    end
  endtask

  task automatic test_stream(input logic ov, input logic [12:0] ey, input int hits);
    logic [12:0] s;
    s = 13'b0111010010101;
    load(3'b101, ov);
    for (int i = 0; i < 13; i++) begin
      tick(s[12-i], 1'b1, 1'b0);
      n_vec++;
      if (y !== ey[12-i]) begin
        n_err++;
        $display("FAIL stream_ov%0b bit%0d: y=%b, required %b", ov, i + 1, y, ey[12-i]);
      end
    end
    n_vec++;
    if (det_cnt !== exp_cnt(hits)) begin
      n_err++;
      $display("FAIL stream_ov%0b count: det_cnt=%0d, required %0d", ov, det_cnt, exp_cnt(hits));
    end
  endtask

  task automatic test_gap();
    load(3'b101, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (y !== 1'b0) begin
        n_err++;
        $display("FAIL gap_hold[%0d]: y=%b, required 0", i, y);
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b1 || det_cnt !== exp_cnt(1)) begin
      n_err++;
      $display("FAIL gap_hit: y=%b cnt=%0d, required y=1 cnt=%0d", y, det_cnt, exp_cnt(1));
    end
    tick(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (y !== 1'b0 || armed !== 1'b1) begin
      n_err++;
      $display("FAIL gap_after: y=%b armed=%b, required y=0 armed=1", y, armed);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ey;
    ey = 6'b001111;
    load(3'b111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_vec++;
      if (y !== ey[5-i]) begin
        n_err++;
        $display("FAIL b2b bit%0d: y=%b, required %b", i + 1, y, ey[5-i]);
      end
    end
    n_vec++;
    if (det_cnt !== exp_cnt(4)) begin
      n_err++;
      $display("FAIL b2b count: det_cnt=%0d, required %0d", det_cnt, exp_cnt(4));
    end
    load(3'b111, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b1) begin
      n_err++;
      $display("FAIL preload_hit: y=%b, required 1", y);
    end
    tick(1'b1, 1'b1, 1'b1);
    n_vec++;
    if (y !== 1'b0 || det_cnt !== '0) begin
      n_err++;
      $display("FAIL load_priority: y=%b cnt=%0d, required y=0 cnt=0", y, det_cnt);
    end
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b0) begin
      n_err++;
      $display("FAIL discarded_bit: y=%b, required 0", y);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b1 || det_cnt !== exp_cnt(1)) begin
      n_err++;
      $display("FAIL after_load_hit: y=%b cnt=%0d, required y=1 cnt=%0d", y, det_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_reset_mid();
    load(3'b101, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (y !== 1'b0 || armed !== 1'b0 || det_cnt !== '0) begin
      n_err++;
      $display("FAIL async_reset: y=%b armed=%b cnt=%0d, required 0 0 0", y, armed, det_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b0 || armed !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: y=%b armed=%b, required 0 0", y, armed);
    end
  endtask

  task automatic test_saturate();
    load(3'b111, 1'b1);
    for (int i = 0; i < 262; i++) tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (y !== 1'b1 || det_cnt !== exp_cnt(255)) begin
      n_err++;
      $display("FAIL saturate: y=%b cnt=%0d, required y=1 cnt=%0d", y, det_cnt, exp_cnt(255));
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b1, 13'b0000010000101, 3);
    test_stream(1'b0, 13'b0000010000100, 2);
    test_gap();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
